microwave_timer_seq: RTL and testbench

Sequencer for the microwave cook timer. It takes the keypad encoder outputs (bcd, loadn) and shifts the entered digits into a 3-digit M:SS BCD register. On start it counts the register down to zero using a 1 Hz tick enable. It drives the magnetron enable, holds the encoder disabled while cooking, and pauses when the door opens.

---
 rtl/microwave_timer_seq_if.sv | 27 ++
 rtl/microwave_timer_seq.sv | 125 ++++++++++++
 tb/tb_microwave_timer_seq.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/microwave_timer_seq_if.sv
// Keypad/button/door inputs and M:SS display/control outputs of the cook-timer sequencer.
// master drives the inputs (board/bench); slave is the sequencer.
interface microwave_timer_seq_if;
    logic [3:0] bcd;
    logic       loadn;
    logic       startn;
    logic       stopn;
    logic       door_closed;
    logic       tick_1hz;
    logic [3:0] min_ones;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic       enablen;
    logic       mag_on;
    logic       zero;
    logic       done;

    modport master (
        output bcd, loadn, startn, stopn, door_closed, tick_1hz,
        input  min_ones, sec_tens, sec_ones, enablen, mag_on, zero, done
    );

    modport slave (
        input  bcd, loadn, startn, stopn, door_closed, tick_1hz,
        output min_ones, sec_tens, sec_ones, enablen, mag_on, zero, done
    );
endinterface

// File: rtl/microwave_timer_seq.sv
// Microwave cook-timer sequencer: shifts keypad digits into an M:SS BCD register,
// counts it down on a 1 Hz tick, drives the magnetron and pauses on door open.
module microwave_timer_seq #(
    parameter int unsigned DIGITS_MAX    = 9,
    parameter int unsigned SEC_TENS_WRAP = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    microwave_timer_seq_if.slave  bus
);
    localparam logic [3:0] TensWrap = 4'(SEC_TENS_WRAP);

    typedef enum logic [2:0] {StIdle, StEntry, StRun, StPause, StDone} state_e;

    state_e     state_q, state_d;
    logic [3:0] min_q, min_d, tens_q, tens_d, ones_q, ones_d;
    logic       mag_on_q, enablen_q, done_q;

    // Two-stage sampling: an event is a 1->0 step between consecutive samples.
    logic load_s_q, load_p_q, start_s_q, start_p_q, stop_s_q, stop_p_q;
    logic load_ev, start_ev, stop_ev, digit_ok, zero, can_start;

    assign load_ev   = load_p_q & ~load_s_q;
    assign start_ev  = start_p_q & ~start_s_q;
    assign stop_ev   = stop_p_q & ~stop_s_q;
    assign digit_ok  = 32'(bus.bcd) <= DIGITS_MAX;
    assign zero      = (min_q == 4'd0) && (tens_q == 4'd0) && (ones_q == 4'd0);
    assign can_start = start_ev && bus.door_closed && !zero;

    always_comb begin
        state_d = state_q;
        min_d   = min_q;
        tens_d  = tens_q;
        ones_d  = ones_q;
        unique case (state_q)
            StIdle, StEntry: begin
                if (state_q == StEntry && stop_ev) begin
                    state_d = StIdle;
                    min_d   = 4'd0;
                    tens_d  = 4'd0;
                    ones_d  = 4'd0;
                end else if (state_q == StEntry && can_start) begin
                    state_d = StRun;
                end else if (load_ev && digit_ok) begin
                    state_d = StEntry;
                    min_d   = tens_q;
                    tens_d  = ones_q;
                    ones_d  = bus.bcd;
                end
            end
            StRun: begin
                if (!bus.door_closed || stop_ev) begin
                    state_d = StPause;
                end else if (bus.tick_1hz) begin
                    if (ones_q != 4'd0) begin
                        ones_d = ones_q - 4'd1;
                    end else if (tens_q != 4'd0) begin
                        tens_d = tens_q - 4'd1;
                        ones_d = 4'd9;
                    end else if (min_q != 4'd0) begin
                        min_d  = min_q - 4'd1;
                        tens_d = TensWrap;
                        ones_d = 4'd9;
                    end
                    if (min_d == 4'd0 && tens_d == 4'd0 && ones_d == 4'd0) begin
                        state_d = StDone;
                    end
                end
            end
            StPause: begin
                if (stop_ev) begin
                    state_d = StIdle;
                    min_d   = 4'd0;
                    tens_d  = 4'd0;
                    ones_d  = 4'd0;
                end else if (can_start) begin
                    state_d = StRun;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            min_q     <= 4'd0;
            tens_q    <= 4'd0;
            ones_q    <= 4'd0;
            mag_on_q  <= 1'b0;
            enablen_q <= 1'b0;
            done_q    <= 1'b0;
            load_s_q  <= 1'b1;
            load_p_q  <= 1'b1;
            start_s_q <= 1'b1;
            start_p_q <= 1'b1;
            stop_s_q  <= 1'b1;
            stop_p_q  <= 1'b1;
        end else begin
            state_q   <= state_d;
            min_q     <= min_d;
            tens_q    <= tens_d;
            ones_q    <= ones_d;
            // Outputs decode the next state so they move on the same edge as the state.
            mag_on_q  <= (state_d == StRun);
            enablen_q <= (state_d == StRun) || (state_d == StDone);
            done_q    <= (state_d == StDone);
            load_s_q  <= bus.loadn;
            load_p_q  <= load_s_q;
            start_s_q <= bus.startn;
            start_p_q <= start_s_q;
            stop_s_q  <= bus.stopn;
            stop_p_q  <= stop_s_q;
        end
    end

    assign bus.min_ones = min_q;
    assign bus.sec_tens = tens_q;
    assign bus.sec_ones = ones_q;
    assign bus.enablen  = enablen_q;
    assign bus.mag_on   = mag_on_q;
    assign bus.zero     = zero;
    assign bus.done     = done_q;
endmodule

// File: tb/tb_microwave_timer_seq.sv
// Directed bench for the cook-timer sequencer; digits are compared as a packed 12-bit M:SS value.
module tb_microwave_timer_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    microwave_timer_seq_if bus ();

    microwave_timer_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_digits(input string tag, input logic [11:0] exp);
        chk(tag, {20'd0, bus.min_ones, bus.sec_tens, bus.sec_ones}, {20'd0, exp});
    endtask

    task automatic press_load(input logic [3:0] d);
        bus.bcd   = d;
        bus.loadn = 1'b0;
        cyc(3);
        bus.loadn = 1'b1;
        cyc(2);
    endtask

    task automatic press_start();
        bus.startn = 1'b0;
        cyc(3);
        bus.startn = 1'b1;
        cyc(2);
    endtask

    task automatic press_stop();
        bus.stopn = 1'b0;
        cyc(3);
        bus.stopn = 1'b1;
        cyc(2);
    endtask

    task automatic tick();
        bus.tick_1hz = 1'b1;
        cyc(1);
        bus.tick_1hz = 1'b0;
    endtask

    initial begin
        bus.bcd = 4'd0;
        bus.loadn = 1'b1;
        bus.startn = 1'b1;
        bus.stopn = 1'b1;
        bus.door_closed = 1'b1;
        bus.tick_1hz = 1'b0;
        cyc(2);
        rst = 1'b0;
        chk_digits("reset_digits", 12'h000);
        chk("reset_enablen", 32'(bus.enablen), 32'd0);
        chk("reset_mag_on", 32'(bus.mag_on), 32'd0);
        chk("reset_done", 32'(bus.done), 32'd0);
        chk("reset_zero", 32'(bus.zero), 32'd1);

        // Start with zero=1 in IDLE is ignored.
        press_start();
        chk("start_zero_mag", 32'(bus.mag_on), 32'd0);

        // Entry 1:30, run three ticks.
        press_load(4'd1);
        press_load(4'd3);
        press_load(4'd0);
        chk_digits("entry_130", 12'h130);
        chk("entry_enablen", 32'(bus.enablen), 32'd0);
        press_start();
        chk("run_mag_on", 32'(bus.mag_on), 32'd1);
        chk("run_enablen", 32'(bus.enablen), 32'd1);
        tick();
        tick();
        tick();
        chk_digits("run_127", 12'h127);
        press_stop();
        chk("stop_to_pause_mag", 32'(bus.mag_on), 32'd0);
        chk_digits("pause_held_127", 12'h127);
        press_stop();
        chk_digits("pause_stop_clear", 12'h000);

        // 0:01 -> 0:00 with a single-cycle done pulse.
        press_load(4'd1);
        press_start();
        tick();
        chk_digits("done_digits", 12'h000);
        chk("done_pulse", 32'(bus.done), 32'd1);
        chk("done_mag_off", 32'(bus.mag_on), 32'd0);
        chk("done_enablen", 32'(bus.enablen), 32'd1);
        cyc(1);
        chk("done_one_cycle", 32'(bus.done), 32'd0);
        chk("idle_enablen", 32'(bus.enablen), 32'd0);

        // Minute borrow: 1:00 -> 0:59.
        press_load(4'd1);
        press_load(4'd0);
        press_load(4'd0);
        press_start();
        tick();
        chk_digits("borrow_059", 12'h059);
        press_stop();
        press_stop();

        // Unnormalised 0:99 -> 0:98.
        press_load(4'd9);
        press_load(4'd9);
        chk_digits("entry_099", 12'h099);
        press_start();
        tick();
        chk_digits("run_098", 12'h098);
        press_stop();
        press_stop();

        // Door open pauses; close and restart resumes.
        press_load(4'd4);
        press_load(4'd5);
        press_start();
        bus.door_closed = 1'b0;
        cyc(1);
        chk("door_open_mag", 32'(bus.mag_on), 32'd0);
        chk("door_open_enablen", 32'(bus.enablen), 32'd0);
        tick();
        chk_digits("door_open_held", 12'h045);
        bus.door_closed = 1'b1;
        press_start();
        chk("resume_mag", 32'(bus.mag_on), 32'd1);
        chk_digits("resume_045", 12'h045);
        tick();
        chk_digits("resume_044", 12'h044);
        bus.door_closed = 1'b0;
        cyc(1);
        bus.door_closed = 1'b1;
        press_stop();
        chk_digits("pause_stop_idle", 12'h000);
        chk("pause_stop_enablen", 32'(bus.enablen), 32'd0);

        // Start with door open in ENTRY is ignored.
        press_load(4'd5);
        bus.door_closed = 1'b0;
        press_start();
        chk("door_open_start", 32'(bus.mag_on), 32'd0);
        bus.door_closed = 1'b1;
        // Invalid code does not shift.
        press_load(4'hF);
        chk_digits("invalid_bcd", 12'h005);
        // Long low on loadn shifts exactly once.
        bus.bcd = 4'd5;
        bus.loadn = 1'b0;
        cyc(10);
        bus.loadn = 1'b1;
        cyc(2);
        chk_digits("held_loadn", 12'h055);
        press_stop();
        chk_digits("entry_stop_clear", 12'h000);

        // Stop event and tick land on the same edge at 0:10.
        press_load(4'd1);
        press_load(4'd0);
        press_start();
        bus.stopn = 1'b0;
        cyc(1);
        bus.tick_1hz = 1'b1;
        cyc(1);
        bus.tick_1hz = 1'b0;
        chk_digits("stop_tick_held", 12'h010);
        chk("stop_tick_mag", 32'(bus.mag_on), 32'd0);
        bus.stopn = 1'b1;
        cyc(2);

        // Reset mid-RUN.
        press_start();
        chk("rerun_mag", 32'(bus.mag_on), 32'd1);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        chk_digits("midrun_rst_digits", 12'h000);
        chk("midrun_rst_mag", 32'(bus.mag_on), 32'd0);
        chk("midrun_rst_enablen", 32'(bus.enablen), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
